// File: rtl/wall_column_gen_if.sv
// Request/column handshake between the physics datapath and the wall column generator.
interface wall_column_gen_if #(
  parameter int COL_H = 100
);
  logic             start;
  logic             req;
  logic             busy;
  logic             col_valid;
  logic [COL_H-1:0] col_data;
  logic             col_hwall;
  logic             map_end;

  modport master (
    output start, req,
    input  busy, col_valid, col_data, col_hwall, map_end
  );

  modport slave (
    input  start, req,
    output busy, col_valid, col_data, col_hwall, map_end
  );
endinterface

// File: rtl/wall_column_gen.sv
// Generates one wall column per request: a gap that narrows and drifts, ending in a zero column.
// Define WALL_LFSR_EN for pseudo-random gap drift; otherwise the gap bounces up and down.
module wall_column_gen #(
  parameter int COL_H   = 100,
  parameter int MAX_GAP = 60,
  parameter int MIN_GAP = 24,
  parameter int MAP_LEN = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  wall_column_gen_if.slave bus
);

  localparam int                 CNT_W    = $clog2(MAP_LEN + 1);
  localparam logic [7:0]         TOP_INIT = 8'((COL_H - MAX_GAP) / 2);
  localparam logic [7:0]         GAP_INIT = 8'(MAX_GAP);
  localparam logic [7:0]         GAP_MIN  = 8'(MIN_GAP);
  localparam logic [7:0]         HEIGHT   = 8'(COL_H);
  localparam logic [CNT_W-1:0]   CNT_END  = CNT_W'(MAP_LEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_BUILD, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_busy;
  logic              w_col_valid;

  logic [CNT_W-1:0]  r_col_count;
  logic [7:0]        r_gap_w;
  logic [7:0]        r_gap_top;
  logic [COL_H-1:0]  r_col_data;
  logic              r_col_hwall;
  logic              r_map_end;

  logic              w_width_dec;
  logic [7:0]        w_gap_w_nxt;
  logic [7:0]        w_hi;
  logic signed [7:0] w_delta;
  logic signed [7:0] w_raw;
  logic [7:0]        w_gap_top_nxt;
  logic              w_clamp_hit;
  logic              w_at_end;
  logic              w_hwall;
  logic [COL_H-1:0]  w_col;

`ifdef WALL_LFSR_EN
  logic [15:0]       r_lfsr;
  logic              w_lfsr_fb;
`else
  logic              r_dir_up;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state; start overrides everything, including a coincident req
  always_comb begin
    w_state_nxt = r_state;
    if (bus.start) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.req) w_state_nxt = S_CALC;
        S_CALC:  w_state_nxt = S_BUILD;
        S_BUILD: w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    w_busy      = 1'b0;
    w_col_valid = 1'b0;
    case (r_state)
      S_CALC, S_BUILD: w_busy      = 1'b1;
      S_DONE:          w_col_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef WALL_LFSR_EN
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_comb begin
    case (r_lfsr[2:0])
      3'd0:    w_delta = -8'sd2;
      3'd1:    w_delta = -8'sd1;
      3'd6:    w_delta = 8'sd1;
      3'd7:    w_delta = 8'sd2;
      default: w_delta = 8'sd0;
    endcase
  end
`else
  assign w_delta = r_dir_up ? 8'sd1 : -8'sd1;
`endif

  // Gap narrows every 64 columns; position clamp uses the already-narrowed width
  always_comb begin
    w_width_dec = (r_col_count != '0) && (r_col_count[5:0] == 6'd0);
    w_gap_w_nxt = (w_width_dec && (r_gap_w > GAP_MIN)) ? r_gap_w - 8'd1 : r_gap_w;
    w_hi        = HEIGHT - w_gap_w_nxt - 8'd1;
    w_raw       = $signed(r_gap_top) + w_delta;
    w_clamp_hit = 1'b0;
    if (w_raw < 8'sd1) begin
      w_gap_top_nxt = 8'd1;
      w_clamp_hit   = 1'b1;
    end else if (w_raw > $signed(w_hi)) begin
      w_gap_top_nxt = w_hi;
      w_clamp_hit   = 1'b1;
    end else begin
      w_gap_top_nxt = $unsigned(w_raw);
    end
  end

  assign w_at_end = (r_col_count == CNT_END);
  assign w_hwall  = w_at_end || (r_col_count[6:0] < 7'd124);

  always_comb begin
    w_col = '0;
    for (int j = 0; j < COL_H; j++) begin
      w_col[j] = !w_at_end &&
                 ((j < int'(r_gap_top)) || (j >= int'(r_gap_top) + int'(r_gap_w)));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col_count <= '0;
      r_gap_w     <= GAP_INIT;
      r_gap_top   <= TOP_INIT;
      r_col_data  <= '0;
      r_col_hwall <= 1'b1;
      r_map_end   <= 1'b0;
`ifdef WALL_LFSR_EN
      r_lfsr      <= 16'hACE1;
`else
      r_dir_up    <= 1'b1;
`endif
    end else if (bus.start) begin
      // column outputs deliberately keep their last value across a restart
      r_col_count <= '0;
      r_gap_w     <= GAP_INIT;
      r_gap_top   <= TOP_INIT;
      r_map_end   <= 1'b0;
`ifdef WALL_LFSR_EN
      r_lfsr      <= 16'hACE1;
`else
      r_dir_up    <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_CALC: begin
          r_gap_w   <= w_gap_w_nxt;
          r_gap_top <= w_gap_top_nxt;
`ifdef WALL_LFSR_EN
          r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
`else
          if (w_clamp_hit) r_dir_up <= !r_dir_up;
`endif
        end
        S_BUILD: begin
          r_col_data  <= w_col;
          r_col_hwall <= w_hwall;
          if (w_at_end) r_map_end   <= 1'b1;
          else          r_col_count <= r_col_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.col_valid = w_col_valid;
  assign bus.col_data  = r_col_data;
  assign bus.col_hwall = r_col_hwall;
  assign bus.map_end   = r_map_end;

endmodule
